// File: rtl/vco_phase_decoder.sv
// vco_phase_decoder: receive end of the VCO-ADC path.
// Synchronises the ring-oscillator phase taps, decodes the ring code to a
// phase index, integrates the per-clock modulo phase advance over DECIM
// enabled clocks and hands each frame sum out through a valid/ready port.
//
// Handshake: out_valid high means out_data holds an unconsumed sample; the
// sample is consumed on any clk edge where out_valid and out_ready are both
// high. out_data is stable while out_valid is high and not consumed. A frame
// that closes while the holding register is still full is dropped and the
// sticky overrun flag is raised.
module vco_phase_decoder #(
    parameter int PHASE_WIDTH = 11,
    parameter int DECIM       = 512,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PHASE_WIDTH-1:0] p,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    localparam int RING  = 2 * PHASE_WIDTH;
    localparam int POS_W = $clog2(RING);
    localparam int PC_W  = $clog2(PHASE_WIDTH + 1);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PHASE_WIDTH-1:0] s1;
    logic [PHASE_WIDTH-1:0] s2;
    logic [PC_W-1:0]        ones;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_q;
    logic [POS_W-1:0]       pos_prev;
    logic [POS_W:0]         diff_wide;
    logic [POS_W-1:0]       d;
    logic                   primed;
    logic [OUT_WIDTH-1:0]   acc;
    logic [OUT_WIDTH-1:0]   result;
    logic [CNT_W-1:0]       cnt;
    logic                   frame_close;

    // Two-flop synchroniser for the asynchronous phase taps; always running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= p;
            s2 <= s1;
        end
    end

    // Ring-code decode: popcount, mirrored once the top tap is set, so a
    // single bubble only perturbs the index slightly.
    always_comb begin
        ones = '0;
        for (int i = 0; i < PHASE_WIDTH; i++) begin
            ones = ones + PC_W'(s2[i]);
        end
        if (s2[PHASE_WIDTH-1]) begin
            pos = POS_W'(RING) - POS_W'(ones);
        end else begin
            pos = POS_W'(ones);
        end
    end

    // Forward-only modulo phase difference, frame-close detect and the
    // running frame sum including the current difference.
    always_comb begin
        diff_wide = {1'b0, pos_q} - {1'b0, pos_prev};
        if (pos_q < pos_prev) begin
            diff_wide = diff_wide + (POS_W + 1)'(RING);
        end
        d           = diff_wide[POS_W-1:0];
        frame_close = enable && primed && (cnt == CNT_W'(DECIM - 1));
        result      = acc + OUT_WIDTH'(d);
    end

    // Phase pipeline, priming and integrate-and-dump; all hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q    <= '0;
            pos_prev <= '0;
            primed   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else if (enable) begin
            pos_q    <= pos;
            pos_prev <= pos_q;
            primed   <= 1'b1;
            if (primed) begin
                if (frame_close) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= result;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_close) begin
                if (!out_valid || out_ready) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (frame_close && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vco_phase_decoder.sv
// Testbench for vco_phase_decoder: phase-index reference model feeding a
// scoreboard queue, table-driven step-rate and ring-code vectors, and
// hand-written sequences for backpressure, enable pause and async reset.
module tb_vco_phase_decoder;

    localparam int N     = 11;
    localparam int RING  = 2 * N;
    localparam int DECIM = 512;
    localparam int OW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [N-1:0]  p;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          clear_overrun;

    // 50 MHz system clock
    always #10 clk = ~clk;

    vco_phase_decoder #(
        .PHASE_WIDTH(N),
        .DECIM      (DECIM),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .p            (p),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    typedef struct {
        int step;
        int exp_frame;
    } step_vec_t;

    typedef struct {
        logic [N-1:0] code;
        int           pos;
    } dec_vec_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            ctrl_err = 0;
    int            release_cyc = 0;
    logic [31:0]   last_pop = '0;
    int            rise_q[$];
    logic [OW-1:0] exp_q[$];
    logic          pv = 1'b0;
    int            cur_pos = 0;

    // reference model state (phase indices, not ring codes)
    int            m_s1, m_s2, m_posq, m_prev, m_acc, m_cnt;
    bit            m_primed, m_valid, m_ovr;
    logic [OW-1:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] enc(input int k);
        logic [N-1:0] all_ones;
        all_ones = '1;
        if (k <= N) return all_ones >> (N - k);
        else        return all_ones << (k - N);
    endfunction

    task automatic set_phase(input int k);
        cur_pos = k;
        p = enc(k);
    endtask

    task automatic set_code(input logic [N-1:0] c, input int k);
        cur_pos = k;
        p = c;
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_posq = 0; m_prev = 0; m_acc = 0; m_cnt = 0;
        m_primed = 0; m_valid = 0; m_ovr = 0; m_data = '0;
    endtask

    // advance the model by one clk edge using the inputs currently driven
    task automatic model_edge();
        int n_s1, n_s2, n_posq, n_prev, n_acc, n_cnt, d, res;
        bit n_primed, close, ovr_set;
        n_s1 = cur_pos; n_s2 = m_s1;
        n_posq = m_posq; n_prev = m_prev; n_acc = m_acc; n_cnt = m_cnt;
        n_primed = m_primed; close = 0; ovr_set = 0; res = 0;
        if (enable) begin
            n_posq = m_s2;
            n_prev = m_posq;
            n_primed = 1;
            if (m_primed) begin
                d = (m_posq - m_prev + RING) % RING;
                if (m_cnt == DECIM - 1) begin
                    close = 1; res = m_acc + d; n_acc = 0; n_cnt = 0;
                end else begin
                    n_acc = m_acc + d; n_cnt = m_cnt + 1;
                end
            end
        end
        if (close) begin
            if (!m_valid || out_ready) begin
                m_data = res[OW-1:0];
                m_valid = 1;
                exp_q.push_back(res[OW-1:0]);
            end else begin
                ovr_set = 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (clear_overrun) m_ovr = 0;
        m_s1 = n_s1; m_s2 = n_s2; m_posq = n_posq; m_prev = n_prev;
        m_acc = n_acc; m_cnt = n_cnt; m_primed = n_primed;
    endtask

    // one clock: scoreboard pop on handshake, model step, edge, tracking
    task automatic cycle();
        logic [OW-1:0] e;
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e));
                last_pop = 32'(out_data);
            end
        end
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        if (out_valid !== m_valid || overrun !== m_ovr || out_data !== m_data) ctrl_err++;
        if (out_valid === 1'b1 && !pv) rise_q.push_back(cyc);
        pv = out_valid;
    endtask

    task automatic run(input int n, input int step);
        repeat (n) begin
            set_phase((cur_pos + step) % RING);
            cycle();
        end
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        rise_q.delete();
        pv = 1'b0;
        set_phase(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        release_cyc = cyc;
    endtask

    task automatic check_ctrl(input string name);
        check(name, 32'(ctrl_err), 0);
        ctrl_err = 0;
    endtask

    step_vec_t step_tab[5];
    dec_vec_t  dec_tab[8];

    initial begin
        step_tab[0] = '{0, 0};
        step_tab[1] = '{1, 512};
        step_tab[2] = '{3, 1536};
        step_tab[3] = '{5, 2560};
        step_tab[4] = '{21, 10752};

        dec_tab[0] = '{11'h000, 0};
        dec_tab[1] = '{11'h001, 1};
        dec_tab[2] = '{11'h03F, 6};
        dec_tab[3] = '{11'h7FF, 11};
        dec_tab[4] = '{11'h7FE, 12};
        dec_tab[5] = '{11'h400, 21};
        dec_tab[6] = '{11'h00B, 3};
        dec_tab[7] = '{11'h7BF, 12};

        // power-on reset state
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1; clear_overrun = 1'b0;
        set_phase(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_overrun", 32'(overrun), 0);

        // constant phase rates, including the 21 -> 0 wrap for all steps > 0
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            do_reset();
            run(3 * DECIM + 8, step_tab[i].step);
            if (rise_q.size() < 3) begin
                check("rise_count", 32'(rise_q.size()), 3);
            end else begin
                check("first_valid_latency", 32'(rise_q[0] - release_cyc), DECIM + 1);
                check("frame_interval", 32'(rise_q[2] - rise_q[1]), DECIM);
            end
            check("steady_frame", last_pop, 32'(step_tab[i].exp_frame));
            check_ctrl("ctrl_track_step");
        end

        // ring-code decode including bubbled codes
        do_reset();
        run(DECIM + 8, 0);
        for (int i = 0; i < 8; i++) begin
            set_code(dec_tab[i].code, dec_tab[i].pos);
            hold(DECIM);
            set_phase(0);
            hold(DECIM);
        end
        check_ctrl("ctrl_track_decode");

        // backpressure across two frame closes, then clear and drain
        do_reset();
        out_ready = 1'b1;
        run(2 * DECIM + 20, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 1200 && !m_ovr; k++) run(1, 1);
        check("ovr_valid_held", 32'(out_valid), 1);
        check("ovr_data_kept", 32'(out_data), 512);
        check("ovr_flag_set", 32'(overrun), 1);
        clear_overrun = 1'b1;
        run(1, 1);
        clear_overrun = 1'b0;
        check("ovr_flag_cleared", 32'(overrun), 0);
        out_ready = 1'b1;
        run(1, 1);
        check("valid_drop_after_accept", 32'(out_valid), 0);
        run(DECIM / 2, 1);
        check("valid_stays_low", 32'(out_valid), 0);
        check_ctrl("ctrl_track_overrun");

        // enable low for 100 clks mid-frame while the phase keeps moving
        do_reset();
        run(700, 1);
        enable = 1'b0;
        run(100, 1);
        enable = 1'b1;
        run(400, 1);
        check("pause_frame_sum", last_pop, 524);
        run(500, 1);
        if (rise_q.size() < 3) begin
            check("pause_rise_count", 32'(rise_q.size()), 3);
        end else begin
            check("pause_frame_interval", 32'(rise_q[1] - rise_q[0]), DECIM + 100);
            check("post_pause_interval", 32'(rise_q[2] - rise_q[1]), DECIM);
        end
        check_ctrl("ctrl_track_pause");

        // asynchronous reset at clk 300 of a frame with a sample held
        out_ready = 1'b0;
        run(600, 1);
        for (int k = 0; k < 600 && m_cnt != 300; k++) run(1, 1);
        if (m_cnt != 300) check("mid_frame_reach", 32'(m_cnt), 300);
        check("pre_reset_valid", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 0);
        check("async_reset_data", 32'(out_data), 0);
        check("async_reset_overrun", 32'(overrun), 0);
        do_reset();
        out_ready = 1'b1;
        run(DECIM + 8, 1);
        if (rise_q.size() < 1) check("post_reset_rise", 0, 1);
        else check("post_reset_latency", 32'(rise_q[0] - release_cyc), DECIM + 1);
        check_ctrl("ctrl_track_reset");
        check("sb_drain", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
